// File: rtl/x_andn_pkg.sv
// Shared constants and elaboration-time helpers for the AND/NAND reduction tree.
// Tree depth, per-level node count and index width are all derived here.
package x_andn_pkg;

  localparam int MODE_AND  = 0;
  localparam int MODE_NAND = 1;

  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Number of nodes in tree level 'level' (level 0 sits directly on the inputs).
  function automatic int nodes_f(input int width, input int group, input int level);
    int n;
    n = width;
    for (int i = 0; i <= level; i++) n = (n + group - 1) / group;
    return n;
  endfunction

  function automatic int lat_f(input int width, input int group);
    int n;
    int l;
    n = width;
    l = 0;
    while (n > 1) begin
      n = (n + group - 1) / group;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/x_andn_pipe_if.sv
// Operand/result bundle for x_andn_pipe; master drives operands, slave returns results.
interface x_andn_pipe_if import x_andn_pkg::*; #(
  parameter int WIDTH = 16
) ();

  logic                        CE;
  logic [WIDTH-1:0]            I;
  logic                        I_VLD;
  logic                        O;
  logic                        O_VLD;
  logic                        ZANY;
  logic [clog2_f(WIDTH)-1:0]   ZIDX;

  modport master (output CE, I, I_VLD, input O, O_VLD, ZANY, ZIDX);
  modport slave  (input CE, I, I_VLD, output O, O_VLD, ZANY, ZIDX);

endinterface

// File: rtl/x_and_stage.sv
// One tree node: GROUP-input AND with lowest-zero index select, registered with
// a valid bit; data only reloads on a valid enabled cycle.
module x_and_stage #(
  parameter int GROUP = 4,
  parameter int IW    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ce,
  input  logic                      i_vld,
  input  logic [GROUP-1:0]          i_zero,
  input  logic [GROUP-1:0][IW-1:0]  i_idx,
  output logic                      o_vld,
  output logic                      o_zero,
  output logic                      o_all,
  output logic [IW-1:0]             o_idx
);

  logic          w_anyZero;
  logic [IW-1:0] w_selIdx;
  logic          r_vld;
  logic          r_zero;
  logic          r_all;
  logic [IW-1:0] r_idx;

  // Scanning high-to-low lets the lowest zero-carrying child win.
  always_comb begin
    w_anyZero = |i_zero;
    w_selIdx  = '0;
    for (int g = GROUP - 1; g >= 0; g--) begin
      if (i_zero[g]) w_selIdx = i_idx[g];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_zero <= 1'b0;
      r_all  <= 1'b0;
      r_idx  <= '0;
    end else if (i_ce) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_zero <= w_anyZero;
        r_all  <= ~w_anyZero;
        r_idx  <= w_selIdx;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_zero = r_zero;
  assign o_all  = r_all;
  assign o_idx  = r_idx;

endmodule

// File: rtl/x_andn_pipe.sv
// Pipelined WIDTH-input AND/NAND reduction with zero detection and lowest-zero
// index, built as a GROUP-ary tree of registered x_and_stage nodes.
module x_andn_pipe import x_andn_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int MODE  = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VLD,
  output logic                       O,
  output logic                       O_VLD,
  output logic                       ZANY,
  output logic [clog2_f(WIDTH)-1:0]  ZIDX
);

  localparam int LAT   = lat_f(WIDTH, GROUP);
  localparam int IW    = clog2_f(WIDTH);
  localparam int MAXN  = nodes_f(WIDTH, GROUP, 0);
  localparam int MAXIN = MAXN * GROUP;

  // Row l holds the zero flags/indices feeding tree level l; row LAT is the root.
  logic [LAT:0][MAXIN-1:0]          w_lvlZero;
  logic [LAT:0][MAXIN-1:0][IW-1:0]  w_lvlIdx;
  logic [LAT:0]                     w_lvlVld;
  logic [LAT-1:0][MAXN-1:0]         w_nodeVld;
  logic [LAT-1:0][MAXN-1:0]         w_nodeAll;
  logic                             w_unused;

  // Padding leaves carry no zero, so they can never be selected as ZIDX.
  for (genvar p = 0; p < MAXIN; p++) begin : g_leaf
    if (p < WIDTH) begin : g_in
      assign w_lvlZero[0][p] = ~I[p];
      assign w_lvlIdx[0][p]  = IW'(p);
    end else begin : g_pad
      assign w_lvlZero[0][p] = 1'b0;
      assign w_lvlIdx[0][p]  = '0;
    end
  end

  assign w_lvlVld[0] = I_VLD;

  for (genvar l = 0; l < LAT; l++) begin : g_lvl
    localparam int NN = nodes_f(WIDTH, GROUP, l);
    for (genvar n = 0; n < MAXN; n++) begin : g_node
      if (n < NN) begin : g_real
        x_and_stage #(
          .GROUP (GROUP),
          .IW    (IW)
        ) u_stage (
          .i_clk  (CLK),
          .i_rst  (RST),
          .i_ce   (CE),
          .i_vld  (w_lvlVld[l]),
          .i_zero (w_lvlZero[l][n*GROUP +: GROUP]),
          .i_idx  (w_lvlIdx[l][n*GROUP +: GROUP]),
          .o_vld  (w_nodeVld[l][n]),
          .o_zero (w_lvlZero[l+1][n]),
          .o_all  (w_nodeAll[l][n]),
          .o_idx  (w_lvlIdx[l+1][n])
        );
      end else begin : g_pad
        assign w_nodeVld[l][n]   = 1'b1;
        assign w_nodeAll[l][n]   = 1'b0;
        assign w_lvlZero[l+1][n] = 1'b0;
        assign w_lvlIdx[l+1][n]  = '0;
      end
    end
    for (genvar p = MAXN; p < MAXIN; p++) begin : g_fill
      assign w_lvlZero[l+1][p] = 1'b0;
      assign w_lvlIdx[l+1][p]  = '0;
    end
    assign w_lvlVld[l+1] = &w_nodeVld[l];
  end

  // Root registers reset to zero, so O reads 0 after reset in either polarity.
  assign O_VLD = w_lvlVld[LAT];
  assign ZANY  = w_lvlZero[LAT][0];
  assign ZIDX  = w_lvlIdx[LAT][0];
  assign O     = (MODE == MODE_NAND) ? w_lvlZero[LAT][0] : w_nodeAll[LAT-1][0];

  assign w_unused = ^{w_lvlZero, w_lvlIdx, w_nodeVld, w_nodeAll};

endmodule

// File: tb/tb_x_andn_pipe.sv
// Scoreboard bench: directed vectors push hand-computed results; a negedge
// monitor pops and compares whenever a result is presented.
module tb_x_andn_pipe;
  import x_andn_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic       o;
    logic       zany;
    logic [5:0] zidx;
    int         due;
  } expT;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   enCount;
  logic lastEn;
  logic lastRst;
  logic started;
  expT  sbA[$];
  expT  sbB[$];
  logic       hO[2];
  logic       hZ[2];
  logic [5:0] hI[2];
  logic       hV[2];

  x_andn_pipe_if #(.WIDTH(16)) ifA ();
  x_andn_pipe_if #(.WIDTH(10)) ifB ();

  x_andn_pipe #(.WIDTH(16), .GROUP(4), .MODE(MODE_AND)) dutA (
    .CLK   (clock),
    .RST   (reset),
    .CE    (ifA.CE),
    .I     (ifA.I),
    .I_VLD (ifA.I_VLD),
    .O     (ifA.O),
    .O_VLD (ifA.O_VLD),
    .ZANY  (ifA.ZANY),
    .ZIDX  (ifA.ZIDX)
  );

  x_andn_pipe #(.WIDTH(10), .GROUP(4), .MODE(MODE_NAND)) dutB (
    .CLK   (clock),
    .RST   (reset),
    .CE    (ifB.CE),
    .I     (ifB.I),
    .I_VLD (ifB.I_VLD),
    .O     (ifB.O),
    .O_VLD (ifB.O_VLD),
    .ZANY  (ifB.ZANY),
    .ZIDX  (ifB.ZIDX)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Track which edges actually advanced the pipeline.
  always @(posedge clock) begin
    lastRst <= reset;
    lastEn  <= ifA.CE && !reset;
    if (reset) started <= 1'b1;
    else if (ifA.CE) enCount <= enCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitorStep(input int d, input logic vld, input logic o,
                             input logic zany, input logic [5:0] zidx);
    expT   e;
    int    n;
    string t;
    t = (d == 0) ? "A" : "B";
    n = (d == 0) ? sbA.size() : sbB.size();
    if (lastRst) begin
      checkOutput({t, " reset O_VLD"}, 32'(vld), 0);
      checkOutput({t, " reset O"}, 32'(o), 0);
      checkOutput({t, " reset ZANY"}, 32'(zany), 0);
      checkOutput({t, " reset ZIDX"}, 32'(zidx), 0);
      hO[d] = 1'b0; hZ[d] = 1'b0; hI[d] = '0; hV[d] = 1'b0;
    end else if (!lastEn) begin
      checkOutput({t, " frozen O_VLD"}, 32'(vld), 32'(hV[d]));
      checkOutput({t, " frozen O"}, 32'(o), 32'(hO[d]));
      checkOutput({t, " frozen ZANY"}, 32'(zany), 32'(hZ[d]));
      checkOutput({t, " frozen ZIDX"}, 32'(zidx), 32'(hI[d]));
    end else if (vld === 1'b1) begin
      if (n == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s unexpected result: got O=%0d ZIDX=%0d expected no O_VLD", t, o, zidx);
      end else begin
        if (d == 0) e = sbA.pop_front();
        else        e = sbB.pop_front();
        checkOutput({t, " O"}, 32'(o), 32'(e.o));
        checkOutput({t, " ZANY"}, 32'(zany), 32'(e.zany));
        checkOutput({t, " ZIDX"}, 32'(zidx), 32'(e.zidx));
        checkOutput({t, " latency"}, enCount, e.due);
        hO[d] = e.o; hZ[d] = e.zany; hI[d] = e.zidx; hV[d] = 1'b1;
      end
    end else begin
      checkOutput({t, " idle O_VLD"}, 32'(vld), 0);
      checkOutput({t, " held O"}, 32'(o), 32'(hO[d]));
      checkOutput({t, " held ZANY"}, 32'(zany), 32'(hZ[d]));
      checkOutput({t, " held ZIDX"}, 32'(zidx), 32'(hI[d]));
      hV[d] = 1'b0;
      if (n > 0) begin
        if (d == 0) e = sbA[0];
        else        e = sbB[0];
        if (e.due <= enCount) begin
          total++;
          bad++;
          $display("[TB] FAIL %s missing result: got O_VLD=0 expected O_VLD=1", t);
          if (d == 0) void'(sbA.pop_front());
          else        void'(sbB.pop_front());
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      monitorStep(0, ifA.O_VLD, ifA.O, ifA.ZANY, {2'b00, ifA.ZIDX});
      monitorStep(1, ifB.O_VLD, ifB.O, ifB.ZANY, {2'b00, ifB.ZIDX});
    end
  end

  task automatic applyStimulus(input logic ce, input logic vld, input logic [15:0] vec,
                               input logic eo, input logic ez, input int ei);
    ifA.CE    = ce;
    ifB.CE    = ce;
    ifA.I_VLD = vld;
    ifA.I     = vec;
    ifB.I_VLD = 1'b0;
    if (ce && vld) sbA.push_back('{o: eo, zany: ez, zidx: 6'(ei), due: enCount + LAT});
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulusB(input logic [9:0] vec, input logic eo, input logic ez, input int ei);
    ifA.CE    = 1'b1;
    ifB.CE    = 1'b1;
    ifA.I_VLD = 1'b0;
    ifB.I_VLD = 1'b1;
    ifB.I     = vec;
    sbB.push_back('{o: eo, zany: ez, zidx: 6'(ei), due: enCount + LAT});
    @(posedge clock);
    #2;
  endtask

  task automatic doReset(input logic vld, input logic [15:0] vec);
    reset     = 1'b1;
    ifA.CE    = 1'b1;
    ifB.CE    = 1'b1;
    ifA.I_VLD = vld;
    ifA.I     = vec;
    ifB.I_VLD = vld;
    ifB.I     = vec[9:0];
    @(posedge clock);
    #1;
    sbA.delete();
    sbB.delete();
    #1;
    reset     = 1'b0;
    ifA.I_VLD = 1'b0;
    ifB.I_VLD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    enCount = 0;
    lastEn = 1'b0;
    lastRst = 1'b0;
    started = 1'b0;
    ifA.I = '0;
    ifB.I = '0;
    doReset(1'b0, 16'h0000);
    // Vector presented together with reset must be discarded.
    doReset(1'b1, 16'hFFFF);
    idle(3);

    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 16'hFF7F, 1'b0, 1'b1, 7);
    applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 15);
    applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 0);
    idle(3);

    applyStimulus(1'b1, 1'b1, 16'hEFFF, 1'b0, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    idle(3);

    applyStimulus(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 16'hFDFF, 1'b0, 1'b1, 9);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 0);
    idle(3);

    applyStimulus(1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 16'hBFFF, 1'b0, 1'b1, 14);
    doReset(1'b0, 16'h0000);
    idle(4);

    applyStimulusB(10'h3FF, 1'b0, 1'b0, 0);
    applyStimulusB(10'h1FF, 1'b1, 1'b1, 9);
    applyStimulusB(10'h3FE, 1'b1, 1'b1, 0);
    applyStimulusB(10'h2FF, 1'b1, 1'b1, 8);
    applyStimulusB(10'h155, 1'b1, 1'b1, 1);

    for (int k = 0; k < 20; k++) begin
      if (sbA.size() == 0 && sbB.size() == 0) break;
      idle(1);
    end
    idle(2);
    checkOutput("A drain", sbA.size(), 0);
    checkOutput("B drain", sbB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_andn_pipe.md
X_ANDN_PIPE -- requirements
Module: x_andn_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of data inputs reduced, legal 2..64.
REQ-002 SHALL have parameter GROUP, default 4: fan-in per pipeline stage, legal 2..8.
REQ-003 SHALL have parameter MODE, default 0: output polarity, 0 = AND, 1 = NAND.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port CE, input, 1: clock enable; low freezes the whole pipeline.
REQ-007 SHALL have port I, input, WIDTH: operand vector; bit k is input k.
REQ-008 SHALL have port I_VLD, input, 1: I is valid this cycle.
REQ-009 SHALL have port O, output, 1: reduced result.
REQ-010 SHALL have port O_VLD, output, 1: O, ZANY and ZIDX are valid.
REQ-011 SHALL have port ZANY, output, 1: at least one input bit was 0.
REQ-012 SHALL have port ZIDX, output, clog2(WIDTH): lowest index k with I[k] = 0; 0 when ZANY = 0.

Function
REQ-013 SHALL compute O = AND of I[WIDTH-1:0] for MODE 0 and its inverse for MODE 1.
REQ-014 SHALL implement a tree of LAT = ceil(log_GROUP(WIDTH)) registered stages, minimum 1; each stage reduces GROUP-wide groups.
REQ-015 SHALL pad unused leaf positions of the last group with logic 1 (AND identity), never reported by ZIDX.
REQ-016 SHALL present the result of a vector sampled with I_VLD = 1 and CE = 1 exactly LAT enabled cycles later, with O_VLD = 1.
REQ-017 SHALL accept one vector per enabled cycle, with no bubbles; throughput 1/cycle.
REQ-018 SHALL propagate a valid bit alongside data in each stage; a stage with valid 0 holds its data unchanged.
REQ-019 SHALL, at each tree node, select the lowest-indexed child containing a zero and carry its index upward, giving ZIDX.
REQ-020 SHALL, while CE = 0, hold every stage register, including O, O_VLD, ZANY and ZIDX; no vector is lost or duplicated.
REQ-021 SHALL ignore I when I_VLD = 0; the corresponding output cycle has O_VLD = 0 and O/ZANY/ZIDX hold their previous values.
REQ-022 SHALL, when I_VLD and CE rise in the same cycle as RST, discard the vector (RST wins).

Reset
REQ-023 SHALL, on an RST-sampled edge, clear all stage valid bits, with O = 0, O_VLD = 0, ZANY = 0 and ZIDX = 0 the next cycle, regardless of MODE or CE.
REQ-024 SHALL, on reset mid-operation, drop all in-flight vectors; the first O_VLD after reset comes from a vector sampled after RST deasserts.
REQ-025 SHALL give RST priority over CE.

Structure
REQ-026 SHALL place in shared package x_andn_pkg: MODE_AND/MODE_NAND constants, LAT computation function, and the clog2 helper.
REQ-027 SHALL use one sub-module, x_and_stage: a GROUP-input AND-with-zero-index node plus its valid/data/index register and CE hold; instantiated via generate per node.
REQ-028 SHALL contain no latches, no asynchronous logic and no combinational path from I to O.

Verification (WIDTH=16, GROUP=4, MODE=0, LAT=2 unless noted)
REQ-029 SHALL cover I=16'hFFFF, I_VLD=1 at cycle 0 -> cycle 2: O=1, O_VLD=1, ZANY=0, ZIDX=0.
REQ-030 SHALL cover back-to-back 16'hFF7F, 16'h7FFF, 16'hFFFE on cycles 0-2 -> cycles 2-4: O=0/0/0, ZANY=1, ZIDX=7/15/0, O_VLD high for 3 cycles.
REQ-031 SHALL cover two vectors in flight, then CE=0 for 3 cycles -> outputs frozen; after CE=1, both results appear in order, each exactly once.
REQ-032 SHALL cover RST=1 for one cycle with two vectors in flight -> the next cycle O_VLD=0, O=0; no stale result ever emitted.
REQ-033 SHALL cover MODE=1, WIDTH=10, GROUP=4 (LAT=2): I=10'h3FF -> O=0, ZANY=0; I=10'h1FF -> O=1, ZIDX=9; padding never reported.
REQ-034 SHALL cover an I_VLD pattern 1,0,1 -> O_VLD pattern 1,0,1 offset by LAT, with held values during the gap.
